// File: rtl/multi_clken_gen_pkg.sv
// clkgen_pkg: shared definitions for the multi-channel clock-enable generator.
// Holds the control FSM state encoding, default parameter values and a
// helper that sizes the channel-select field.
package clkgen_pkg;

   localparam int DEF_NUM_CH      = 4;
   localparam int DEF_ACC_W       = 16;
   localparam int DEF_LOCK_CYCLES = 16;

   typedef enum logic [1:0] {
      ST_RST    = 2'd0,
      ST_SETTLE = 2'd1,
      ST_LOCKED = 2'd2,
      ST_APPLY  = 2'd3
   } clkgen_state_t;

   // Width of the channel-select field; never narrower than one bit.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multi_clken_gen_if.sv
// multi_clken_gen_if: configuration handshake bundle.
// Ports (as signals): cfg_valid/cfg_ready handshake, cfg_ch target channel,
// cfg_inc phase increment, cfg_phase accumulator load value, cfg_en enable.
interface multi_clken_gen_if
   import clkgen_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int ACC_W  = DEF_ACC_W
);
   localparam int CH_W = ch_width(NUM_CH);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [ACC_W-1:0] cfg_inc;
   logic [ACC_W-1:0] cfg_phase;
   logic             cfg_en;

   modport master (
      output cfg_valid, cfg_ch, cfg_inc, cfg_phase, cfg_en,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_inc, cfg_phase, cfg_en,
      output cfg_ready
   );

endinterface

// File: rtl/multi_clken_gen_phase_acc.sv
// clken_phase_acc: one phase-accumulator channel.
// Ports: i_clk/i_rst, i_run (FSM out of reset), i_load + i_load_* (config
// write), o_clken (registered wrap pulse), o_clk_sq (accumulator MSB).
module clken_phase_acc
   import clkgen_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_run,
   input  logic             i_load,
   input  logic [ACC_W-1:0] i_load_inc,
   input  logic [ACC_W-1:0] i_load_phase,
   input  logic             i_load_en,
   output logic             o_clken,
   output logic             o_clk_sq
);

   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_inc;
   logic             r_en;
   logic             r_clken;
   logic [ACC_W:0]   w_sum;

   // One extra bit so the wrap shows up as the carry.
   assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc   <= '0;
         r_inc   <= '0;
         r_en    <= 1'b0;
         r_clken <= 1'b0;
      end else if (i_load) begin
         // A load replaces the running state and suppresses any pulse.
         r_acc   <= i_load_phase;
         r_inc   <= i_load_inc;
         r_en    <= i_load_en;
         r_clken <= 1'b0;
      end else if (r_en && i_run) begin
         r_acc   <= w_sum[ACC_W-1:0];
         r_clken <= w_sum[ACC_W];
      end else begin
         r_clken <= 1'b0;
      end
   end

   assign o_clken  = r_clken;
   assign o_clk_sq = r_acc[ACC_W-1];

endmodule

// File: rtl/multi_clken_gen.sv
// multi_clken_gen: NUM_CH phase-accumulator clock-enable generators with a
// config handshake and a lock indicator. Ports: i_refclk, i_rst (sync, high),
// cfg_if (slave handshake), o_clken, o_clk_sq, o_locked.
module multi_clken_gen
   import clkgen_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int ACC_W       = DEF_ACC_W,
   parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
   input  logic              i_refclk,
   input  logic              i_rst,
   multi_clken_gen_if.slave  cfg_if,
   output logic [NUM_CH-1:0] o_clken,
   output logic [NUM_CH-1:0] o_clk_sq,
   output logic              o_locked
);

   localparam int CNT_W = ($clog2(LOCK_CYCLES) > 8) ? $clog2(LOCK_CYCLES) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

   clkgen_state_t    r_state;
   clkgen_state_t    w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_ready;
   logic             w_ch_ok;
   logic             w_load;
   logic             w_run;

   assign w_ready = (r_state == ST_SETTLE) || (r_state == ST_LOCKED);
   assign w_ch_ok = int'(cfg_if.cfg_ch) < NUM_CH;
   // An out-of-range channel still completes the handshake but loads nothing
   // and leaves the FSM untouched.
   assign w_load  = cfg_if.cfg_valid && w_ready && w_ch_ok;
   assign w_run   = (r_state != ST_RST);

   assign cfg_if.cfg_ready = w_ready;
   assign o_locked         = (r_state == ST_LOCKED);

   always_ff @(posedge i_refclk) begin
      if (i_rst) begin
         r_state <= ST_RST;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (w_load) begin
         w_state_nxt = ST_APPLY;
      end else begin
         case (r_state)
            ST_RST: begin
               w_state_nxt = ST_SETTLE;
               w_cnt_nxt   = '0;
            end
            ST_SETTLE: begin
               if (r_cnt == CNT_LAST) w_state_nxt = ST_LOCKED;
               else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            ST_LOCKED: w_state_nxt = ST_LOCKED;
            ST_APPLY: begin
               w_state_nxt = ST_SETTLE;
               w_cnt_nxt   = '0;
            end
            default: w_state_nxt = ST_RST;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clken_phase_acc #(
         .ACC_W (ACC_W)
      ) u_acc (
         .i_clk        (i_refclk),
         .i_rst        (i_rst),
         .i_run        (w_run),
         .i_load       (w_load && (int'(cfg_if.cfg_ch) == g)),
         .i_load_inc   (cfg_if.cfg_inc),
         .i_load_phase (cfg_if.cfg_phase),
         .i_load_en    (cfg_if.cfg_en),
         .o_clken      (o_clken[g]),
         .o_clk_sq     (o_clk_sq[g])
      );
   end

endmodule

// File: tb/tb_multi_clken_gen.sv
// Bench for multi_clken_gen: table-driven vectors plus hand-written corner
// sequences, every cycle checked against a behavioural scoreboard model.
// A second NUM_CH=5 instance covers out-of-range channel selects.
module tb_multi_clken_gen;
   import clkgen_pkg::*;

   localparam int NCH = 4;
   localparam int AW  = 16;
   localparam int LC  = 16;
   localparam int M_RST = 0, M_SETTLE = 1, M_LOCKED = 2, M_APPLY = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b1;
   always #5 clk = ~clk;

   multi_clken_gen_if #(.NUM_CH(NCH), .ACC_W(AW)) cfg_if ();
   logic [NCH-1:0] clken, clk_sq;
   logic           locked;
   multi_clken_gen #(.NUM_CH(NCH), .ACC_W(AW), .LOCK_CYCLES(LC)) dut (
      .i_refclk(clk), .i_rst(rst), .cfg_if(cfg_if),
      .o_clken(clken), .o_clk_sq(clk_sq), .o_locked(locked));

   multi_clken_gen_if #(.NUM_CH(5), .ACC_W(AW)) if2 ();
   logic [4:0] clken2, clk_sq2;
   logic       locked2;
   multi_clken_gen #(.NUM_CH(5), .ACC_W(AW), .LOCK_CYCLES(LC)) dut2 (
      .i_refclk(clk), .i_rst(rst2), .cfg_if(if2),
      .o_clken(clken2), .o_clk_sq(clk_sq2), .o_locked(locked2));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, got, exp);
      end
   endtask

   // ---------------- scoreboard model ----------------
   typedef struct packed {
      logic [NCH-1:0] clken;
      logic [NCH-1:0] clk_sq;
      logic           locked;
      logic           ready;
   } exp_t;
   exp_t sb_q[$];

   int          m_st;
   int          m_cnt;
   logic [15:0] m_acc[NCH];
   logic [15:0] m_inc[NCH];
   logic        m_en[NCH];
   logic [NCH-1:0] m_clken;

   task automatic model_step(input bit r, input bit v, input int ch,
                             input logic [15:0] inc, input logic [15:0] ph, input bit en);
      bit rdy, ld;
      logic [16:0] s;
      exp_t e;
      rdy = (m_st == M_SETTLE) || (m_st == M_LOCKED);
      ld  = v && rdy && (ch < NCH);
      if (r) begin
         m_st = M_RST; m_cnt = 0; m_clken = '0;
         for (int i = 0; i < NCH; i++) begin m_acc[i] = '0; m_inc[i] = '0; m_en[i] = 1'b0; end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (ld && ch == i) begin
               m_inc[i] = inc; m_acc[i] = ph; m_en[i] = en; m_clken[i] = 1'b0;
            end else if (m_en[i] && m_st != M_RST) begin
               s = {1'b0, m_acc[i]} + {1'b0, m_inc[i]};
               m_acc[i] = s[15:0]; m_clken[i] = s[16];
            end else begin
               m_clken[i] = 1'b0;
            end
         end
         if (ld) m_st = M_APPLY;
         else case (m_st)
            M_RST:    begin m_st = M_SETTLE; m_cnt = 0; end
            M_SETTLE: if (m_cnt == LC - 1) m_st = M_LOCKED; else m_cnt++;
            M_APPLY:  begin m_st = M_SETTLE; m_cnt = 0; end
            default:  ;
         endcase
      end
      for (int i = 0; i < NCH; i++) e.clk_sq[i] = m_acc[i][15];
      e.clken  = m_clken;
      e.locked = (m_st == M_LOCKED);
      e.ready  = (m_st == M_SETTLE) || (m_st == M_LOCKED);
      sb_q.push_back(e);
   endtask

   // Drive one cycle, push the expectation, compare after the edge.
   // 'acc' reports whether the DUT handshake completed on this edge.
   task automatic drive(input bit r, input bit v, input int ch, input logic [15:0] inc,
                        input logic [15:0] ph, input bit en, output bit acc);
      exp_t e;
      rst = r;
      cfg_if.cfg_valid = v; cfg_if.cfg_ch = 2'(ch);
      cfg_if.cfg_inc = inc; cfg_if.cfg_phase = ph; cfg_if.cfg_en = en;
      acc = v && cfg_if.cfg_ready && !r;
      model_step(r, v, ch, inc, ph, en);
      @(posedge clk); #1;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk("sb_clken",  32'(clken),            32'(e.clken));
         chk("sb_clk_sq", 32'(clk_sq),           32'(e.clk_sq));
         chk("sb_locked", 32'(locked),           32'(e.locked));
         chk("sb_ready",  32'(cfg_if.cfg_ready), 32'(e.ready));
      end
   endtask

   task automatic idle(input int n);
      bit a;
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 0, 16'h0, 16'h0, 1'b0, a);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          r;
      bit          v;
      int          ch;
      logic [15:0] inc;
      logic [15:0] ph;
      bit          en;
      int          cyc;
      int          pch;
      int          exp_p;
      bit          exp_lk;
   } vec_t;
   vec_t tbl[10];

   function automatic vec_t mk(input bit r, input bit v, input int ch, input logic [15:0] inc,
                               input logic [15:0] ph, input bit en, input int cyc,
                               input int pch, input int exp_p, input bit exp_lk);
      vec_t t;
      t.r = r; t.v = v; t.ch = ch; t.inc = inc; t.ph = ph; t.en = en;
      t.cyc = cyc; t.pch = pch; t.exp_p = exp_p; t.exp_lk = exp_lk;
      return t;
   endfunction

   bit a;
   int p, t2, t3, stage, cnt_bad;

   initial begin
      m_st = M_RST; m_cnt = 0; m_clken = '0;
      for (int i = 0; i < NCH; i++) begin m_acc[i] = '0; m_inc[i] = '0; m_en[i] = 1'b0; end
      cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_inc = '0;
      cfg_if.cfg_phase = '0; cfg_if.cfg_en = 1'b0;
      if2.cfg_valid = 1'b0; if2.cfg_ch = '0; if2.cfg_inc = '0;
      if2.cfg_phase = '0; if2.cfg_en = 1'b0;

      //            r     v     ch inc       phase     en   cyc pch pulses locked
      tbl[0] = mk(1'b1, 1'b0, 0, 16'h0000, 16'h0000, 1'b0,  3, 0, 0, 1'b0); // reset
      tbl[1] = mk(1'b0, 1'b0, 0, 16'h0000, 16'h0000, 1'b0, 16, 0, 0, 1'b0); // edges 1..16
      tbl[2] = mk(1'b0, 1'b0, 0, 16'h0000, 16'h0000, 1'b0,  1, 0, 0, 1'b1); // edge 17
      tbl[3] = mk(1'b0, 1'b1, 0, 16'h4000, 16'h0000, 1'b1, 16, 0, 3, 1'b0); // ch0 /4
      tbl[4] = mk(1'b0, 1'b0, 0, 16'h0000, 16'h0000, 1'b0,  1, 0, 1, 1'b0); // accept+16
      tbl[5] = mk(1'b0, 1'b0, 0, 16'h0000, 16'h0000, 1'b0,  1, 0, 0, 1'b1); // accept+17
      tbl[6] = mk(1'b0, 1'b1, 1, 16'h6000, 16'h0000, 1'b1,  9, 1, 3, 1'b0); // 3 per 8
      tbl[7] = mk(1'b0, 1'b1, 1, 16'h8000, 16'h8000, 1'b1,  1, 1, 0, 1'b0); // load clears
      tbl[8] = mk(1'b0, 1'b0, 0, 16'h0000, 16'h0000, 1'b0,  1, 1, 1, 1'b0); // first after APPLY
      tbl[9] = mk(1'b0, 1'b0, 0, 16'h0000, 16'h0000, 1'b0,  4, 1, 2, 1'b0); // every 2nd

      for (int k = 0; k < 10; k++) begin
         p = 0;
         for (int c = 0; c < tbl[k].cyc; c++) begin
            drive(tbl[k].r, (c == 0) ? tbl[k].v : 1'b0, tbl[k].ch, tbl[k].inc,
                  tbl[k].ph, tbl[k].en, a);
            p += int'(clken[tbl[k].pch]);
         end
         chk($sformatf("vec%0d_pulses", k), p, tbl[k].exp_p);
         chk($sformatf("vec%0d_locked", k), 32'(locked), 32'(tbl[k].exp_lk));
      end

      // Back-to-back requests held valid: ch2 then ch3.
      t2 = -1; t3 = -1; stage = 0;
      for (int c = 0; c < 12 && stage < 2; c++) begin
         if (stage == 0) drive(1'b0, 1'b1, 2, 16'h2000, 16'h8000, 1'b1, a);
         else            drive(1'b0, 1'b1, 3, 16'h1000, 16'hF000, 1'b1, a);
         if (a) begin
            if (stage == 0) begin
               t2 = c;
               chk("b2b_ch2_sq", 32'(clk_sq[2]), 32'd1);
               chk("b2b_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
            end else begin
               t3 = c;
            end
            stage++;
         end
      end
      chk("b2b_gap", t3 - t2, 2);
      idle(1);
      chk("b2b_ch3_pulse", 32'(clken[3]), 32'd1);

      // Zero increment with enable: frozen accumulator, no pulses.
      drive(1'b0, 1'b1, 2, 16'h0000, 16'h9234, 1'b1, a);
      chk("inc0_accept", 32'(a), 32'd1);
      p = 0; cnt_bad = 0;
      for (int c = 0; c < 10; c++) begin
         idle(1);
         p += int'(clken[2]);
         if (clk_sq[2] !== 1'b1) cnt_bad++;
      end
      chk("inc0_pulses", p, 0);
      chk("inc0_frozen", cnt_bad, 0);

      // Reset landing in APPLY, with several channels running.
      drive(1'b0, 1'b1, 1, 16'h8000, 16'h0000, 1'b1, a);
      chk("rst_pre_accept", 32'(a), 32'd1);
      drive(1'b1, 1'b1, 0, 16'h1111, 16'h0000, 1'b1, a);
      chk("rst_clken", 32'(clken), 32'd0);
      chk("rst_clk_sq", 32'(clk_sq), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
      cnt_bad = 0;
      for (int c = 0; c < 20; c++) begin
         idle(1);
         if ((clken | clk_sq) != '0) cnt_bad++;
      end
      chk("rst_channels_off", cnt_bad, 0);
      chk("rst_relock", 32'(locked), 32'd1);

      // Out-of-range channel on the 5-channel instance.
      rst2 = 1'b0;
      for (int c = 0; c < 16; c++) begin @(posedge clk); #1; end
      chk("oor_lock_edge16", 32'(locked2), 32'd0);
      @(posedge clk); #1;
      chk("oor_lock_edge17", 32'(locked2), 32'd1);
      if2.cfg_valid = 1'b1; if2.cfg_ch = 3'd5; if2.cfg_inc = 16'h4000; if2.cfg_en = 1'b1;
      a = if2.cfg_ready;
      @(posedge clk); #1;
      if2.cfg_valid = 1'b0;
      chk("oor_accept", 32'(a), 32'd1);
      chk("oor_locked", 32'(locked2), 32'd1);
      chk("oor_ready", 32'(if2.cfg_ready), 32'd1);
      cnt_bad = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (clken2 != '0 || clk_sq2 != '0 || locked2 !== 1'b1) cnt_bad++;
      end
      chk("oor_no_change", cnt_bad, 0);
      if2.cfg_valid = 1'b1; if2.cfg_ch = 3'd4; if2.cfg_inc = 16'h0000;
      @(posedge clk); #1;
      if2.cfg_valid = 1'b0;
      chk("inrange_ch4_unlock", 32'(locked2), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/multi_clken_gen.md
MULTI_CLKEN_GEN -- requirements
Module: multi_clken_gen

Interface
REQ-001 Parameter NUM_CH, default 4, number of output channels (1..8).
REQ-002 Parameter ACC_W, default 16, phase-accumulator width (8..32).
REQ-003 Parameter LOCK_CYCLES, default 16, settle count before locked asserts (>=1).
REQ-004 refclk  input  1  sole clock, all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cfg_valid  input  1  config request.
REQ-007 cfg_ready  output  1  config accept.
REQ-008 cfg_ch  input  max(1,clog2(NUM_CH))  target channel.
REQ-009 cfg_inc  input  ACC_W  phase increment; f_out = f_refclk*inc/2^ACC_W.
REQ-010 cfg_phase  input  ACC_W  accumulator load value (phase offset).
REQ-011 cfg_en  input  1  channel enable.
REQ-012 clken  output  NUM_CH  one-cycle enable pulse per channel wrap.
REQ-013 clk_sq  output  NUM_CH  accumulator MSB, approx. 50% square wave.
REQ-014 locked  output  1  all channel settings stable for LOCK_CYCLES.

Function
REQ-015 Per channel i: registers acc[i], inc[i], en[i]; when en[i]=1 and FSM not RST, acc[i] <= (acc[i]+inc[i]) mod 2^ACC_W each edge; en[i]=0 holds acc[i].
REQ-016 clken[i] SHALL be registered: set on the edge where en[i]=1 and acc[i]+inc[i] carries out of bit ACC_W-1, else 0.
REQ-017 clk_sq[i] SHALL equal bit ACC_W-1 of acc[i] (registered, no extra delay).
REQ-018 inc[i]=0 with en[i]=1: acc[i] frozen, clken[i] never pulses.
REQ-019 FSM states RST, SETTLE, LOCKED, APPLY; 8-bit-or-wider settle counter cnt.
REQ-020 RST: while rst=1; first edge with rst=0 -> SETTLE, cnt=0.
REQ-021 SETTLE: cnt increments each edge; edge with cnt=LOCK_CYCLES-1 -> LOCKED.
REQ-022 locked=1 only in LOCKED; rises on the (LOCK_CYCLES+1)th edge after rst deasserts.
REQ-023 cfg_ready=1 in SETTLE and LOCKED, 0 in RST and APPLY.
REQ-024 Accept = cfg_valid & cfg_ready at an edge: same edge loads inc[cfg_ch]<=cfg_inc, acc[cfg_ch]<=cfg_phase, en[cfg_ch]<=cfg_en, clken[cfg_ch]<=0; FSM -> APPLY; locked drops same edge.
REQ-025 APPLY lasts exactly one cycle, then SETTLE with cnt=0; hence max one accept per 2 cycles.
REQ-026 Accept during SETTLE restarts the settle count via APPLY.
REQ-027 cfg_ch >= NUM_CH: handshake completes, no register changes, FSM stays in current state, cnt and locked unaffected.
REQ-028 Non-target channels keep accumulating unaffected through APPLY/SETTLE.

Reset
REQ-029 rst=1 at an edge: acc, inc, en, clken, clk_sq, locked, cfg_ready, cnt all 0; FSM RST; applies mid-operation including during APPLY; pending cfg_valid ignored.

Structure
REQ-030 Package clkgen_pkg holds FSM state enum, default ACC_W and LOCK_CYCLES constants.
REQ-031 Sub-module clken_phase_acc (one channel: acc/inc/en, carry, clken, clk_sq, load port) instantiated NUM_CH times via generate; FSM and handshake in top.

Verification (ACC_W=16, NUM_CH=4, LOCK_CYCLES=16)
REQ-032 Release rst -> locked=0 for edges 1..16, locked=1 from edge 17; cfg_ready=1 from edge 1.
REQ-033 Cfg ch0 inc=0x4000 phase=0 en=1 -> clken[0] every 4th cycle, clk_sq[0] 2 high/2 low; locked drops, returns 17 edges after accept.
REQ-034 Cfg ch1 inc=0x6000 -> exactly 3 clken[1] pulses per 8 cycles; ch1 inc=0x8000 phase=0x8000 -> first pulse on first edge after APPLY.
REQ-035 Back-to-back cfg_valid held for ch2 then ch3 -> accepts 2 cycles apart, cfg_ready low in between, both channels loaded.
REQ-036 cfg_ch=5 while LOCKED -> accepted, locked stays 1, no channel change; inc=0 en=1 -> no clken.
REQ-037 rst pulsed mid-run with 3 channels active -> all outputs 0 next edge, channels stay disabled after release.
